readmem_test: RTL and testbench

Preloadable 1024 x 32 read-only lookup memory with a registered read port, used as a bring-up and debug block for checking `$readmemh` preloading of scene and constant tables before they go into the larger traversal pipeline. Contents are loaded at simulation start through the hierarchical array `mem`. Reads are addressed by `io_rdAddr` and qualified by `io_wrEna`, which enables updates of the output register.

---
 rtl/readmem_test.sv | 45 ++++
 tb/tb_readmem_test.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/readmem_test.sv
// Preloadable read-only lookup memory with a registered, enable-qualified read port.
// Contents come from a hierarchical preload of mem; the RTL never writes it.
module readmem_test #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wrEna,
    input  logic [9:0]        io_rdAddr,
    output logic [DATA_W-1:0] io_rdData,
    output logic              io_rdValid,
    output logic              io_rdOob
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_LIM = 11'(DEPTH);

    reg [DATA_W-1:0] mem [0:DEPTH-1];

    logic in_range;

    assign in_range = ({1'b0, io_rdAddr} < DEPTH_LIM);

    // Only the output registers are reset; mem keeps its preload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_rdData  <= '0;
            io_rdValid <= 1'b0;
            io_rdOob   <= 1'b0;
        end else if (io_wrEna) begin
            io_rdValid <= 1'b1;
            if (in_range) begin
                io_rdData <= mem[io_rdAddr[AW-1:0]];
                io_rdOob  <= 1'b0;
            end else begin
                io_rdData <= '0;
                io_rdOob  <= 1'b1;
            end
        end else begin
            io_rdValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_readmem_test.sv
// Randomized self-checking bench for readmem_test: a 1024-deep and a 512-deep
// instance share stimulus and are compared against an array-based read model.
module tb_readmem_test;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ena   = 1'b0;
    logic [9:0]  addr  = '0;

    logic [31:0] d0, d1;
    logic        v0, v1, o0, o1;

    readmem_test #(.DEPTH(1024), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .io_wrEna(ena), .io_rdAddr(addr),
        .io_rdData(d0), .io_rdValid(v0), .io_rdOob(o0)
    );

    readmem_test #(.DEPTH(512), .DATA_W(32)) dut_s (
        .clock(clock), .reset(reset), .io_wrEna(ena), .io_rdAddr(addr),
        .io_rdData(d1), .io_rdValid(v1), .io_rdOob(o1)
    );

    always #10 clock = ~clock;

    // Packed view {data, valid, oob} per instance.
    logic [33:0] got [2];
    always_comb begin
        got[0] = {d0, v0, o0};
        got[1] = {d1, v1, o1};
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [1024];
    logic [33:0] e [2];
    int          depth [2] = '{1024, 512};

    function automatic logic [33:0] read_word(int k, int a);
        if (a < depth[k]) return {ref_mem[a], 2'b10};
        return {32'h0, 2'b11};
    endfunction

    // Advance one rising edge and apply the read rules to the model.
    task automatic tick();
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (reset)    e[k] = '0;
            else if (ena) e[k] = read_word(k, int'(addr));
            else          e[k][1] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== 34'h0) begin
                    errors++;
                    $display("FAIL reset_hold inst%0d got %h want %h", k, got[k], 34'h0);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] words [4];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        ena = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = 10'(a);
            tick();
            checks++;
            if (got[0] !== {words[a], 2'b10}) begin
                errors++;
                $display("FAIL directed_a%0d got %h want %h", a, got[0], {words[a], 2'b10});
            end
        end
    endtask

    task automatic test_stream();
        ena = 1'b1;
        for (int a = 0; a < 6; a++) begin
            addr = 10'(a);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== e[k] || got[k][1] !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_a%0d inst%0d got %h want %h", a, k, got[k], e[k]);
                end
            end
        end
    endtask

    task automatic test_hold();
        ena  = 1'b1;
        addr = 10'd2;
        tick();
        ena  = 1'b0;
        addr = 10'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (got[0] !== {32'h33333333, 2'b00}) begin
                errors++;
                $display("FAIL hold_c%0d got %h want %h", c, got[0], {32'h33333333, 2'b00});
            end
        end
        ena = 1'b1;
        tick();
        checks++;
        if (got[0] !== {32'h44444444, 2'b10}) begin
            errors++;
            $display("FAIL hold_resume got %h want %h", got[0], {32'h44444444, 2'b10});
        end
    endtask

    task automatic test_oob();
        int probes [5];
        probes = '{600, 1, 511, 512, 1023};
        ena = 1'b1;
        addr = 10'd600;
        tick();
        checks++;
        if (got[1] !== {32'h0, 2'b11}) begin
            errors++;
            $display("FAIL oob_600 got %h want %h", got[1], {32'h0, 2'b11});
        end
        addr = 10'd1;
        tick();
        checks++;
        if (got[1] !== {32'h22222222, 2'b10}) begin
            errors++;
            $display("FAIL oob_then_1 got %h want %h", got[1], {32'h22222222, 2'b10});
        end
        for (int i = 0; i < 5; i++) begin
            addr = 10'(probes[i]);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== e[k]) begin
                    errors++;
                    $display("FAIL edge_a%0d inst%0d got %h want %h", probes[i], k, got[k], e[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        ena = 1'b1;
        for (int c = 0; c < 4; c++) begin
            addr = 10'($urandom_range(0, 1023));
            tick();
        end
        #4;
        reset = 1'b1;
        e[0] = '0;
        e[1] = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got[k] !== 34'h0) begin
                errors++;
                $display("FAIL async_clear inst%0d got %h want %h", k, got[k], 34'h0);
            end
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got[k] !== 34'h0) begin
                errors++;
                $display("FAIL reset_mid inst%0d got %h want %h", k, got[k], 34'h0);
            end
        end
        reset = 1'b0;
        addr  = 10'd3;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got[k] !== {32'h44444444, 2'b10}) begin
                errors++;
                $display("FAIL after_reset inst%0d got %h want %h", k, got[k], {32'h44444444, 2'b10});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            ena  = ($urandom_range(0, 3) != 0);
            addr = 10'($urandom_range(0, 1023));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== e[k]) begin
                    errors++;
                    $display("FAIL rand_c%0d inst%0d got %h want %h", c, k, got[k], e[k]);
                end
            end
            // Address wiggle between edges must not reach the outputs.
            addr = 10'($urandom_range(0, 1023));
            #5;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got[k] !== e[k]) begin
                    errors++;
                    $display("FAIL no_comb_c%0d inst%0d got %h want %h", c, k, got[k], e[k]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h11111111;
        ref_mem[1] = 32'h22222222;
        ref_mem[2] = 32'h33333333;
        ref_mem[3] = 32'h44444444;
        for (int i = 0; i < 1024; i++) dut.mem[i] = ref_mem[i];
        for (int i = 0; i < 512; i++) dut_s.mem[i] = ref_mem[i];
        e[0] = '0;
        e[1] = '0;

        test_reset();
        test_directed();
        test_stream();
        test_hold();
        test_oob();
        test_mid_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
